// File: rtl/param_acc_cpu.sv
`default_nettype none
// ============================================================================
//  Module      : param_acc_cpu
//  Description : Parametrised single-accumulator CPU. Fetches one-word
//                instructions over a shared memory port with a ready-based
//                wait-state handshake and executes LOAD/ADD/SUB/AND/STORE/
//                JMP/JZ/HALT against one accumulator with carry/zero flags.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                mem_rdata       - memory read data (valid with re & ready)
//                mem_ready       - memory completes current access this cycle
//                mem_addr        - registered memory address
//                mem_wdata       - write data (accumulator)
//                mem_re, mem_we  - registered read / write requests
//                acc, pc         - accumulator and program counter
//                carry, zero     - carry/borrow flag, acc == 0
//                halted          - high while in HALT
//  Revision    : 1.0 - initial release
// ============================================================================
module param_acc_cpu #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] acc,
    output logic [ADDR_W-1:0] pc,
    output logic              carry,
    output logic              zero,
    output logic              halted
);

    localparam int OP_W = DATA_W - ADDR_W;

    localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_STORE = OP_W'(3);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_JMP   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_JZ    = OP_W'(7);
    localparam logic [OP_W-1:0] OP_HALT  = {OP_W{1'b1}};

    typedef enum logic [2:0] {
        ST_RESET   = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXEC_RD = 3'd3,
        ST_EXEC_WR = 3'd4,
        ST_HALT    = 3'd5
    } state_t;

    state_t              state, state_next;
    logic [DATA_W-1:0]   ir, ir_next;
    logic [DATA_W-1:0]   acc_next;
    logic [ADDR_W-1:0]   pc_next;
    logic [ADDR_W-1:0]   addr_next;
    logic                carry_next;
    logic                re_next;
    logic                we_next;

    logic [OP_W-1:0]     opcode;
    logic [ADDR_W-1:0]   operand;
    logic [DATA_W:0]     sum;
    logic [DATA_W:0]     diff;

    assign opcode    = ir[DATA_W-1:ADDR_W];
    assign operand   = ir[ADDR_W-1:0];
    // Extra top bit holds carry-out of ADD / borrow of SUB.
    assign sum       = {1'b0, acc} + {1'b0, mem_rdata};
    assign diff      = {1'b0, acc} - {1'b0, mem_rdata};

    assign zero      = (acc == '0);
    assign halted    = (state == ST_HALT);
    assign mem_wdata = acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RESET;
            ir       <= '0;
            acc      <= '0;
            pc       <= '0;
            carry    <= 1'b0;
            mem_addr <= '0;
            mem_re   <= 1'b0;
            mem_we   <= 1'b0;
        end else begin
            state    <= state_next;
            ir       <= ir_next;
            acc      <= acc_next;
            pc       <= pc_next;
            carry    <= carry_next;
            mem_addr <= addr_next;
            mem_re   <= re_next;
            mem_we   <= we_next;
        end
    end

    always_comb begin
        state_next = state;
        ir_next    = ir;
        acc_next   = acc;
        pc_next    = pc;
        carry_next = carry;
        addr_next  = mem_addr;
        re_next    = mem_re;
        we_next    = mem_we;

        case (state)
            ST_RESET: begin
                addr_next  = pc;
                re_next    = 1'b1;
                state_next = ST_FETCH;
            end

            ST_FETCH: begin
                if (mem_ready) begin
                    ir_next    = mem_rdata;
                    pc_next    = pc + ADDR_W'(1);
                    re_next    = 1'b0;
                    state_next = ST_DECODE;
                end
            end

            ST_DECODE: begin
                // Default path is NOP: start fetching the next word at once.
                addr_next  = pc;
                re_next    = 1'b1;
                state_next = ST_FETCH;
                case (opcode)
                    OP_LOAD, OP_ADD, OP_SUB, OP_AND: begin
                        addr_next  = operand;
                        state_next = ST_EXEC_RD;
                    end
                    OP_STORE: begin
                        addr_next  = operand;
                        re_next    = 1'b0;
                        we_next    = 1'b1;
                        state_next = ST_EXEC_WR;
                    end
                    OP_JMP: begin
                        pc_next   = operand;
                        addr_next = operand;
                    end
                    OP_JZ: begin
                        if (zero) begin
                            pc_next   = operand;
                            addr_next = operand;
                        end
                    end
                    OP_HALT: begin
                        re_next    = 1'b0;
                        state_next = ST_HALT;
                    end
                    default: ;
                endcase
            end

            ST_EXEC_RD: begin
                if (mem_ready) begin
                    case (opcode)
                        OP_LOAD: acc_next = mem_rdata;
                        OP_ADD:  {carry_next, acc_next} = sum;
                        OP_SUB:  {carry_next, acc_next} = diff;
                        OP_AND:  acc_next = acc & mem_rdata;
                        default: ;
                    endcase
                    // Read ends and the next fetch is issued in the same edge.
                    addr_next  = pc;
                    re_next    = 1'b1;
                    state_next = ST_FETCH;
                end
            end

            ST_EXEC_WR: begin
                if (mem_ready) begin
                    we_next    = 1'b0;
                    addr_next  = pc;
                    re_next    = 1'b1;
                    state_next = ST_FETCH;
                end
            end

            ST_HALT: ;

            default: state_next = ST_RESET;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_param_acc_cpu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_param_acc_cpu
//  Description : Self-checking bench for param_acc_cpu (DATA_W=16, ADDR_W=8).
//                Small programs from a table are run to HALT and the final
//                architectural state, cycle count and memory writes checked;
//                hand sequences cover wait states, mid-access reset and pc wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_param_acc_cpu;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [15:0] acc;
    logic [7:0]  pc;
    logic        carry;
    logic        zero;
    logic        halted;

    always #5 clk = ~clk;

    param_acc_cpu #(.DATA_W(16), .ADDR_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .acc       (acc),
        .pc        (pc),
        .carry     (carry),
        .zero      (zero),
        .halted    (halted)
    );

    logic [15:0] mem [0:255];
    assign mem_rdata = mem[mem_addr];

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0] p0, p1, p2, p3;   // program words at 0..3
        logic [15:0] d0, d1;           // data words at 0x10, 0x11
        bit          has_wr;
        logic [7:0]  wa;
        logic [15:0] wd;
        logic [15:0] e_acc;
        logic        e_carry;
        logic        e_zero;
        logic [7:0]  e_pc;
        int          e_cycles;
    } vec_t;

    typedef struct {
        logic [7:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t  exp_q[$];
    wr_t  w_e;
    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Memory writes complete on the coming posedge when we & ready are high.
    task automatic tick();
        if (!rst && mem_we && mem_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL write: actual addr=%0h data=%0h required=no write", mem_addr, mem_wdata);
            end else begin
                w_e = exp_q.pop_front();
                chk("write_addr", {24'h0, mem_addr}, {24'h0, w_e.a});
                chk("write_data", {16'h0, mem_wdata}, {16'h0, w_e.d});
            end
            mem[mem_addr] = mem_wdata;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_prog(input vec_t v);
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0]     = v.p0;
        mem[1]     = v.p1;
        mem[2]     = v.p2;
        mem[3]     = v.p3;
        mem[8'h10] = v.d0;
        mem[8'h11] = v.d1;
        mem[8'h20] = 16'hFF00;
        exp_q.delete();
        if (v.has_wr) exp_q.push_back('{a: v.wa, d: v.wd});
    endtask

    // Leaves the bench at a negedge with rst low, before the first run edge.
    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        mem_ready = 1'b1;
        tick();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs from a negedge until halted; optional 3-cycle stalls on the
    // first fetch of address 0 and on the first store.
    task automatic run_to_halt(input bit stall, output int cycles);
        int          stall_left = 0;
        bit          fetch_done = 0;
        bit          store_done = 0;
        logic [7:0]  s_addr;
        logic [15:0] s_wdata;
        logic        s_re, s_we;
        cycles = 0;
        while (1) begin
            if (stall && stall_left > 0) begin
                chk("stall_addr",  {24'h0, mem_addr}, {24'h0, s_addr});
                chk("stall_wdata", {16'h0, mem_wdata}, {16'h0, s_wdata});
                chk("stall_re",    {31'h0, mem_re}, {31'h0, s_re});
                chk("stall_we",    {31'h0, mem_we}, {31'h0, s_we});
                stall_left--;
                mem_ready = 1'b0;
            end else if (stall && ((!fetch_done && mem_re && mem_addr == 8'h00) ||
                                   (!store_done && mem_we))) begin
                if (mem_we) store_done = 1;
                else        fetch_done = 1;
                s_addr     = mem_addr;
                s_wdata    = mem_wdata;
                s_re       = mem_re;
                s_we       = mem_we;
                stall_left = 2;
                mem_ready  = 1'b0;
            end else begin
                mem_ready = 1'b1;
            end
            tick();
            cycles++;
            if (halted) break;
            if (cycles >= 300) begin
                n_cmp++;
                n_fail++;
                $display("FAIL timeout: actual=no halt after %0d cycles required=halt", cycles);
                break;
            end
            @(negedge clk);
        end
        mem_ready = 1'b1;
    endtask

    function automatic vec_t mk(input logic [15:0] p0, p1, p2, p3, d0, d1,
                                input bit has_wr, input logic [7:0] wa, input logic [15:0] wd,
                                input logic [15:0] e_acc, input logic e_carry, input logic e_zero,
                                input logic [7:0] e_pc, input int e_cycles);
        vec_t v;
        v.p0 = p0; v.p1 = p1; v.p2 = p2; v.p3 = p3; v.d0 = d0; v.d1 = d1;
        v.has_wr = has_wr; v.wa = wa; v.wd = wd;
        v.e_acc = e_acc; v.e_carry = e_carry; v.e_zero = e_zero;
        v.e_pc = e_pc; v.e_cycles = e_cycles;
        return v;
    endfunction

    task automatic check_end(input string tag, input vec_t v, input int cycles, input bit chk_cyc);
        chk({tag, "_acc"},    {16'h0, acc}, {16'h0, v.e_acc});
        chk({tag, "_carry"},  {31'h0, carry}, {31'h0, v.e_carry});
        chk({tag, "_zero"},   {31'h0, zero}, {31'h0, v.e_zero});
        chk({tag, "_pc"},     {24'h0, pc}, {24'h0, v.e_pc});
        chk({tag, "_halted"}, {31'h0, halted}, 32'h1);
        chk({tag, "_re_we"},  {30'h0, mem_re, mem_we}, 32'h0);
        chk({tag, "_wr_left"}, exp_q.size(), 32'h0);
        if (chk_cyc) chk({tag, "_cycles"}, cycles, v.e_cycles);
    endtask

    initial begin
        int cycles;
        rst       = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

        //            p0       p1       p2       p3       d0       d1     wr  wa     wd       acc      c  z  pc     cyc
        vecs[0] = mk(16'h0110, 16'h0211, 16'h0312, 16'hFF00, 16'h0005, 16'h0007, 1, 8'h12, 16'h000C, 16'h000C, 0, 0, 8'h04, 12);
        vecs[1] = mk(16'h0110, 16'h0211, 16'hFF00, 16'h0000, 16'hFFFF, 16'h0001, 0, 8'h00, 16'h0000, 16'h0000, 1, 1, 8'h03, 9);
        vecs[2] = mk(16'h0110, 16'h0211, 16'h0411, 16'hFF00, 16'hFFFF, 16'h0001, 0, 8'h00, 16'h0000, 16'hFFFF, 1, 0, 8'h04, 12);
        vecs[3] = mk(16'h0110, 16'h0511, 16'hFF00, 16'h0000, 16'h0FF0, 16'h00FF, 0, 8'h00, 16'h0000, 16'h00F0, 0, 0, 8'h03, 9);
        vecs[4] = mk(16'h0720, 16'hFF00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 8'h00, 16'h0000, 16'h0000, 0, 1, 8'h21, 5);
        vecs[5] = mk(16'h0110, 16'h0720, 16'hFF00, 16'h0000, 16'h0003, 16'h0000, 0, 8'h00, 16'h0000, 16'h0003, 0, 0, 8'h03, 8);
        vecs[6] = mk(16'h0620, 16'hFF00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 8'h00, 16'h0000, 16'h0000, 0, 1, 8'h21, 5);
        vecs[7] = mk(16'h0110, 16'h0A10, 16'hFF00, 16'h0000, 16'h0009, 16'h0000, 0, 8'h00, 16'h0000, 16'h0009, 0, 0, 8'h03, 8);
        vecs[8] = mk(16'h0110, 16'h0411, 16'hFF00, 16'h0000, 16'h0007, 16'h0005, 0, 8'h00, 16'h0000, 16'h0002, 0, 0, 8'h03, 9);
        vecs[9] = mk(16'h0110, 16'h0211, 16'h0510, 16'hFF00, 16'hFFFF, 16'h0002, 0, 8'h00, 16'h0000, 16'h0001, 1, 0, 8'h04, 12);

        for (int i = 0; i < 10; i++) begin
            load_prog(vecs[i]);
            do_reset();
            run_to_halt(1'b0, cycles);
            check_end($sformatf("vec%0d", i), vecs[i], cycles, 1'b1);
        end

        // Wait states on the first fetch and on the store: +3 cycles each.
        load_prog(vecs[0]);
        do_reset();
        run_to_halt(1'b1, cycles);
        check_end("stall", vecs[0], cycles, 1'b0);
        chk("stall_cycles", cycles, 18);
        chk("stall_mem12", {16'h0, mem[8'h12]}, 32'h000C);

        // Reset pulse while the first LOAD is waiting in EXEC_RD.
        load_prog(vecs[0]);
        exp_q.delete();
        do_reset();
        tick();
        @(negedge clk); tick();
        @(negedge clk); tick();
        chk("rst_mid_re",   {31'h0, mem_re}, 32'h1);
        chk("rst_mid_addr", {24'h0, mem_addr}, 32'h10);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("rst_acc",    {16'h0, acc}, 32'h0);
        chk("rst_pc",     {24'h0, pc}, 32'h0);
        chk("rst_carry",  {31'h0, carry}, 32'h0);
        chk("rst_zero",   {31'h0, zero}, 32'h1);
        chk("rst_addr",   {24'h0, mem_addr}, 32'h0);
        chk("rst_re_we",  {30'h0, mem_re, mem_we}, 32'h0);
        chk("rst_halted", {31'h0, halted}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("rst_refetch_re",   {31'h0, mem_re}, 32'h1);
        chk("rst_refetch_addr", {24'h0, mem_addr}, 32'h0);
        exp_q.push_back('{a: 8'h12, d: 16'h000C});
        @(negedge clk);
        run_to_halt(1'b0, cycles);
        check_end("rst_rerun", vecs[0], cycles, 1'b0);

        // pc wrap: JMP 0xFF, undefined opcode at 0xFF, next fetch from 0x00.
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h00] = 16'h06FF;
        mem[8'hFF] = 16'h0A55;
        exp_q.delete();
        do_reset();
        tick();
        @(negedge clk); tick();
        @(negedge clk); tick();
        chk("wrap_jmp_addr", {24'h0, mem_addr}, 32'hFF);
        chk("wrap_jmp_pc",   {24'h0, pc}, 32'hFF);
        @(negedge clk); tick();
        chk("wrap_pc", {24'h0, pc}, 32'h00);
        @(negedge clk); tick();
        chk("wrap_fetch_addr", {24'h0, mem_addr}, 32'h00);
        chk("wrap_fetch_re",   {31'h0, mem_re}, 32'h1);
        chk("wrap_acc",        {16'h0, acc}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
